// File: rtl/bus_dma_pkg.sv
// bus_dma_pkg -- shared definitions for the bus_dma engine.
//   state_e          : DMA sequencer states (IDLE, READ, WRITE, DONE)
//   ADDR_STEP_DEF    : default byte increment between consecutive words
//   *_ADDR           : peripheral register addresses on the rd/wr bus
package bus_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned ADDR_STEP_DEF = 4;

    localparam logic [31:0] TH_ADDR     = 32'h4000_0000;
    localparam logic [31:0] TL_ADDR     = 32'h4000_0004;
    localparam logic [31:0] TCON_ADDR   = 32'h4000_0008;
    localparam logic [31:0] LED_ADDR    = 32'h4000_000C;
    localparam logic [31:0] SWITCH_ADDR = 32'h4000_0010;
    localparam logic [31:0] DIGI_ADDR   = 32'h4000_0014;

endpackage

// File: rtl/bus_dma_if.sv
// bus_dma_if -- peripheral / data-memory bus.
//   rd    : read strobe (initiator -> target)
//   wr    : write strobe (initiator -> target)
//   addr  : 32-bit byte address (initiator -> target)
//   wdata : 32-bit write data (initiator -> target)
//   rdata : 32-bit read data, combinational while rd is high (target -> initiator)
// Modports: master (the DMA engine), slave (the peripheral side).
interface bus_dma_if;

    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);

endinterface

// File: rtl/bus_dma.sv
// bus_dma -- single-channel DMA initiator on the rd/wr peripheral bus.
// Copies len words from src_addr to dst_addr, one READ cycle followed by one
// WRITE cycle per word, then pulses done for one cycle.
// Ports:
//   clk, reset          : clock; asynchronous active-low reset
//   start               : launch request, only looked at in IDLE
//   src_addr, dst_addr  : first source / destination byte address
//   len                 : number of words (0 completes immediately)
//   src_inc, dst_inc    : advance the address by ADDR_STEP per word when set
//   bus                 : bus_dma_if master modport (rd, wr, addr, wdata, rdata)
//   busy, done          : transfer in progress / one-cycle completion pulse
//   irq_en, irq_clr     : interrupt enable / clear (only with DMA_IRQ_EN)
//   irqout              : sticky completion interrupt (tied 0 without DMA_IRQ_EN)
// Build option: define DMA_IRQ_EN to add the completion interrupt flop.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int unsigned ADDR_STEP = ADDR_STEP_DEF,
    parameter int unsigned LEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             src_inc,
    input  logic             dst_inc,
    bus_dma_if.master        bus,
    output logic             busy,
    output logic             done,
`ifdef DMA_IRQ_EN
    input  logic             irq_en,
    input  logic             irq_clr,
`endif
    output logic             irqout
);

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    state_e           state_q,  state_d;
    logic [31:0]      cur_src_q, cur_src_d;
    logic [31:0]      cur_dst_q, cur_dst_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             src_inc_q, src_inc_d;
    logic             dst_inc_q, dst_inc_d;
    logic [31:0]      data_reg_q, data_reg_d;
    logic [31:0]      addr_q, addr_d;

    logic [31:0]      next_src;
    logic [31:0]      next_dst;

    // Address arithmetic wraps naturally at 32 bits.
    assign next_src = src_inc_q ? cur_src_q + STEP : cur_src_q;
    assign next_dst = dst_inc_q ? cur_dst_q + STEP : cur_dst_q;

    // NOTE: every signal gets its default first, so no path through the case
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        cur_dst_d   = cur_dst_q;
        remaining_d = remaining_q;
        src_inc_d   = src_inc_q;
        dst_inc_d   = dst_inc_q;
        data_reg_d  = data_reg_q;
        addr_d      = addr_q;

        // addr is a register loaded on the edge that enters READ/WRITE, so it
        // holds its last value in IDLE and DONE without extra muxing.
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        cur_src_d   = src_addr;
                        cur_dst_d   = dst_addr;
                        remaining_d = len;
                        src_inc_d   = src_inc;
                        dst_inc_d   = dst_inc;
                        addr_d      = src_addr;
                        state_d     = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                data_reg_d = bus.rdata;
                addr_d     = cur_dst_q;
                state_d    = WRITE;
            end
            WRITE: begin
                remaining_d = remaining_q - LEN_W'(1);
                cur_src_d   = next_src;
                cur_dst_d   = next_dst;
                if (remaining_q == LEN_W'(1)) begin
                    state_d = DONE;
                end else begin
                    addr_d  = next_src;
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            remaining_q <= '0;
            src_inc_q   <= 1'b0;
            dst_inc_q   <= 1'b0;
            data_reg_q  <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            remaining_q <= remaining_d;
            src_inc_q   <= src_inc_d;
            dst_inc_q   <= dst_inc_d;
            data_reg_q  <= data_reg_d;
            addr_q      <= addr_d;
        end
    end

    // Strobes decode straight from the state flop, so an async reset drops
    // them at once and no partial write can follow.
    assign bus.rd    = (state_q == READ);
    assign bus.wr    = (state_q == WRITE);
    assign bus.addr  = addr_q;
    assign bus.wdata = data_reg_q;   // only changes on the READ edge
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

`ifdef DMA_IRQ_EN
    logic irq_q;

    // Set has priority over clear when both occur on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else if ((state_q == DONE) && irq_en) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irqout = irq_q;
`else
    assign irqout = 1'b0;
`endif

endmodule
